// File: rtl/flag_ckpt_file_if.sv
// Flag/checkpoint bus between the flag producers and branch resolution
// (master side) and flag_ckpt_file (slave side).
interface flag_ckpt_file_if #(
  parameter int unsigned NUM_FLAGS  = 2,
  parameter int unsigned CKPT_DEPTH = 4
);
  localparam int unsigned CW = $clog2(CKPT_DEPTH + 1);

  logic [NUM_FLAGS-1:0] flag_in;
  logic [NUM_FLAGS-1:0] flag_wr;
  logic                 ckpt_take;
  logic                 ckpt_commit;
  logic                 ckpt_restore;
  logic [NUM_FLAGS-1:0] flags_out;
  logic [CW-1:0]        ckpt_count;
  logic                 ckpt_full;
  logic                 ckpt_empty;
  logic                 ckpt_err;

  modport master (
    output flag_in, flag_wr, ckpt_take, ckpt_commit, ckpt_restore,
    input  flags_out, ckpt_count, ckpt_full, ckpt_empty, ckpt_err
  );

  modport slave (
    input  flag_in, flag_wr, ckpt_take, ckpt_commit, ckpt_restore,
    output flags_out, ckpt_count, ckpt_full, ckpt_empty, ckpt_err
  );
endinterface

// File: rtl/flag_ckpt_file.sv
// Architectural condition flags with a circular checkpoint queue for branch
// speculation. Snapshots are taken at branch issue and resolved in order:
// commit frees the oldest, restore reloads flags from it and flushes the queue.
// Optional macro FLAG_BYPASS_EN: flags_out shows the merged/restored value
// combinationally instead of the registered flags.
module flag_ckpt_file #(
  parameter int unsigned NUM_FLAGS  = 2,
  parameter int unsigned CKPT_DEPTH = 4
) (
  input logic              clk,
  input logic              rst,
  flag_ckpt_file_if.slave  bus
);
  localparam int unsigned CW = $clog2(CKPT_DEPTH + 1);
  localparam int unsigned PW = $clog2(CKPT_DEPTH);

  logic [NUM_FLAGS-1:0] flags_q, flags_d;
  logic [NUM_FLAGS-1:0] entry_q [CKPT_DEPTH];
  logic [PW-1:0]        head_q, head_d;
  logic [PW-1:0]        tail_q, tail_d;
  logic [CW-1:0]        count_q, count_d;
  logic                 err_q, err_d;

  logic [NUM_FLAGS-1:0] merged;
  logic                 empty, full;
  logic                 restore_ok, commit_ok, take_ok;

  assign merged = (flags_q & ~bus.flag_wr) | (bus.flag_in & bus.flag_wr);
  assign empty  = (count_q == '0);
  assign full   = (count_q == CW'(CKPT_DEPTH));

  // Request qualification: restore dominates; take on full needs a freeing commit.
  always_comb begin
    restore_ok = bus.ckpt_restore && !empty;
    commit_ok  = bus.ckpt_commit && !bus.ckpt_restore && !empty;
    take_ok    = bus.ckpt_take && !bus.ckpt_restore && (!full || commit_ok);
    err_d      = (bus.ckpt_take && !bus.ckpt_restore && full && !bus.ckpt_commit) ||
                 (bus.ckpt_commit && empty) ||
                 (bus.ckpt_restore && empty) ||
                 (bus.ckpt_commit && bus.ckpt_restore);
  end

  // Next-state for flags, pointers and occupancy.
  always_comb begin
    flags_d = merged;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (restore_ok) begin
      // Same-cycle writes belong to the squashed path and are discarded.
      flags_d = entry_q[head_q];
      head_d  = tail_q;
      count_d = '0;
    end else begin
      if (commit_ok) head_d = head_q + PW'(1);
      if (take_ok)   tail_d = tail_q + PW'(1);
      count_d = count_q + CW'(take_ok) - CW'(commit_ok);
    end
  end

  // Architectural state with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      flags_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      flags_q <= flags_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  // Snapshot storage; snapshot includes the same-cycle flag write.
  always_ff @(posedge clk) begin
    if (take_ok) entry_q[tail_q] <= merged;
  end

`ifdef FLAG_BYPASS_EN
  assign bus.flags_out = restore_ok ? entry_q[head_q] : merged;
`else
  assign bus.flags_out = flags_q;
`endif

  assign bus.ckpt_count = count_q;
  assign bus.ckpt_full  = full;
  assign bus.ckpt_empty = empty;
  assign bus.ckpt_err   = err_q;
endmodule
